// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges a single-cycle ALU result stream (A) and a buffered
// long-latency result stream (B) into one registered register-file write per
// cycle, dropping x0 writes and briefly stalling the ALU so B cannot starve.
module wb_write_arbiter #(
    parameter int XLEN         = 64,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     a_valid,
    input  logic [4:0]               a_rd,
    input  logic [XLEN-1:0]          a_data,
    output logic                     alu_stall,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [4:0]               b_rd,
    input  logic [XLEN-1:0]          b_data,
    output logic                     regwrite,
    output logic [4:0]               write_reg,
    output logic [XLEN-1:0]          write_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      rdMem_q   [DEPTH];
    logic [XLEN-1:0] dataMem_q [DEPTH];

    logic [AW-1:0]   headPtr_q, headPtr_d;
    logic [AW-1:0]   tailPtr_q, tailPtr_d;
    logic [CW-1:0]   count_q,   count_d;
    logic [SW-1:0]   starveCnt_q, starveCnt_d;
    logic            stall_q,   stall_d;
    logic            regwrite_q, regwrite_d;
    logic [4:0]      writeReg_q, writeReg_d;
    logic [XLEN-1:0] writeData_q, writeData_d;

    logic            fifoNotEmpty;
    logic            aRequest;
    logic            push;
    logic            pop;
    logic [SW-1:0]   starveInc;

    // A full FIFO refuses a push outright, even if it pops in the same cycle,
    // so readiness depends only on the registered occupancy.
    assign b_ready      = (count_q != CW'(DEPTH));
    assign fifoNotEmpty = (count_q != '0);
    assign aRequest     = a_valid && (a_rd != 5'd0);
    assign push         = b_valid && b_ready && (b_rd != 5'd0);
    assign starveInc    = starveCnt_q + SW'(1);

    assign alu_stall  = stall_q;
    assign regwrite   = regwrite_q;
    assign write_reg  = writeReg_q;
    assign write_data = writeData_q;
    assign count      = count_q;

    // Per-cycle arbitration: forced B drain, then A, then B; also tracks how long B has waited.
    always_comb begin
        pop         = 1'b0;
        regwrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        starveCnt_d = '0;
        stall_d     = 1'b0;

        if (stall_q) begin
            pop = fifoNotEmpty;
        end else if (aRequest) begin
            regwrite_d  = 1'b1;
            writeReg_d  = a_rd;
            writeData_d = a_data;
            if (fifoNotEmpty) begin
                starveCnt_d = starveInc;
                stall_d     = (starveInc == SW'(STARVE_LIMIT));
            end
        end else begin
            pop = fifoNotEmpty;
        end

        if (pop) begin
            regwrite_d  = 1'b1;
            writeReg_d  = rdMem_q[headPtr_q];
            writeData_d = dataMem_q[headPtr_q];
        end
    end

    // FIFO pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_comb begin
        headPtr_d = pop  ? headPtr_q + AW'(1) : headPtr_q;
        tailPtr_d = push ? tailPtr_q + AW'(1) : tailPtr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state and the registered write port; reset discards anything in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            headPtr_q   <= '0;
            tailPtr_q   <= '0;
            count_q     <= '0;
            starveCnt_q <= '0;
            stall_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
        end else begin
            headPtr_q   <= headPtr_d;
            tailPtr_q   <= tailPtr_d;
            count_q     <= count_d;
            starveCnt_q <= starveCnt_d;
            stall_q     <= stall_d;
            regwrite_q  <= regwrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
        end
    end

    // FIFO storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            rdMem_q[tailPtr_q]   <= b_rd;
            dataMem_q[tailPtr_q] <= b_data;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: scoreboard bench for wb_write_arbiter. A small
// behavioural model predicts each cycle's write, pushes it to a queue, and the
// queue is popped and compared once the registered write appears.
module tb_wb_write_arbiter;

    localparam int XLEN         = 64;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_t;

    logic                   clock;
    logic                   reset;
    logic                   a_valid;
    logic [4:0]             a_rd;
    logic [XLEN-1:0]        a_data;
    logic                   alu_stall;
    logic                   b_valid;
    logic                   b_ready;
    logic [4:0]             b_rd;
    logic [XLEN-1:0]        b_data;
    logic                   regwrite;
    logic [4:0]             write_reg;
    logic [XLEN-1:0]        write_data;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    wr_t        mFifo[$];
    wr_t        expQ[$];
    int         mStarve;
    bit         mStall;
    logic [4:0] mLastRd;
    logic [63:0] mLastData;

    wb_write_arbiter #(
        .XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .alu_stall(alu_stall),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
        .count(count)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Clears the model to its post-reset state.
    task automatic resetModel();
        mFifo.delete();
        expQ.delete();
        mStarve   = 0;
        mStall    = 1'b0;
        mLastRd   = '0;
        mLastData = '0;
    endtask

    // Drives one cycle of stimulus, predicts the outcome, then checks the write after the edge.
    task automatic applyStimulus(input bit av, input logic [4:0] ard, input logic [63:0] ad,
                                 input bit bv, input logic [4:0] brd, input logic [63:0] bd,
                                 output bit bAcc);
        bit  mReady;
        bit  aReq;
        bit  popM;
        bit  expWr;
        wr_t w;
        wr_t got;
        a_valid = av;
        a_rd    = ard;
        a_data  = ad;
        b_valid = bv;
        b_rd    = brd;
        b_data  = bd;
        #1;
        mReady = (mFifo.size() != DEPTH);
        checkOutput("b_ready", b_ready, mReady);
        checkOutput("alu_stall", alu_stall, mStall);
        checkOutput("count", count, mFifo.size());
        bAcc  = bv && mReady;
        aReq  = av && (ard != 5'd0);
        popM  = 1'b0;
        expWr = 1'b0;
        w     = '0;
        if (mStall) begin
            popM    = (mFifo.size() > 0);
            mStarve = 0;
            mStall  = 1'b0;
        end else if (aReq) begin
            expWr = 1'b1;
            w     = {ard, ad};
            if (mFifo.size() > 0) begin
                mStarve++;
                if (mStarve == STARVE_LIMIT) mStall = 1'b1;
            end else begin
                mStarve = 0;
            end
        end else begin
            popM    = (mFifo.size() > 0);
            mStarve = 0;
        end
        if (popM) begin
            expWr = 1'b1;
            w     = mFifo.pop_front();
        end
        if (bAcc && brd != 5'd0) mFifo.push_back({brd, bd});
        if (expWr) expQ.push_back(w);
        @(posedge clock);
        #1;
        if (expWr) begin
            got = expQ.pop_front();
            checkOutput("regwrite", regwrite, 1);
            checkOutput("write_reg", write_reg, got.rd);
            checkOutput("write_data", write_data, got.data);
            mLastRd   = got.rd;
            mLastData = got.data;
        end else begin
            checkOutput("regwrite_idle", regwrite, 0);
            checkOutput("write_reg_hold", write_reg, mLastRd);
            checkOutput("write_data_hold", write_data, mLastData);
        end
    endtask

    // Idle cycle helper.
    task automatic idleCycle();
        bit acc;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, acc);
    endtask

    // Directed scenarios followed by a randomized stretch.
    initial begin
        bit  acc;
        bit  pend;
        logic [4:0]  pRd;
        logic [63:0] pData;
        int  guard;

        reset   = 1'b0;
        a_valid = 1'b0;
        a_rd    = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_rd    = '0;
        b_data  = '0;
        resetModel();

        // Power-on reset values.
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_regwrite", regwrite, 0);
        checkOutput("rst_write_reg", write_reg, 0);
        checkOutput("rst_write_data", write_data, 0);
        checkOutput("rst_alu_stall", alu_stall, 0);
        checkOutput("rst_count", count, 0);
        reset = 1'b1;
        #1;
        checkOutput("rst_b_ready", b_ready, 1);

        // Plain ALU write, then one idle cycle that must drop regwrite.
        applyStimulus(1'b1, 5'd1, 64'd200, 1'b0, 5'd0, 64'd0, acc);
        checkOutput("alu_rd1", write_reg, 1);
        idleCycle();

        // x0 writes from either source are swallowed.
        applyStimulus(1'b1, 5'd0, 64'd100, 1'b0, 5'd0, 64'd0, acc);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'd77, acc);
        checkOutput("x0_b_accepted", acc, 1);
        idleCycle();
        checkOutput("x0_count", count, 0);

        // Simultaneous A and B: A first, B the cycle after.
        applyStimulus(1'b1, 5'd2, 64'd300, 1'b1, 5'd3, 64'd400, acc);
        checkOutput("simul_rd_a", write_reg, 2);
        checkOutput("simul_count", count, 1);
        idleCycle();
        checkOutput("simul_rd_b", write_reg, 3);
        idleCycle();

        // Fill the FIFO behind a busy ALU, hold a fifth result, then drain in order.
        for (int i = 4; i <= 7; i++) begin
            applyStimulus(1'b1, 5'd20, 64'(1000 + i), 1'b1, 5'(i), 64'(i * 11), acc);
        end
        checkOutput("full_count", count, 4);
        checkOutput("full_b_ready", b_ready, 0);
        applyStimulus(1'b1, 5'd21, 64'd2000, 1'b1, 5'd8, 64'd88, acc);
        checkOutput("full_refused", acc, 0);
        pend  = 1'b1;
        guard = 0;
        while ((pend || mFifo.size() > 0) && guard < 20) begin
            applyStimulus(1'b0, 5'd0, 64'd0, pend, 5'd8, 64'd88, acc);
            if (acc) pend = 1'b0;
            guard++;
        end
        checkOutput("drain_done", guard < 20, 1);
        idleCycle();

        // Asynchronous reset mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd11, 64'(500 + i), 1'b1, 5'(12 + i), 64'(600 + i), acc);
        end
        checkOutput("pre_reset_count", count, 3);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_regwrite", regwrite, 0);
        checkOutput("async_count", count, 0);
        checkOutput("async_alu_stall", alu_stall, 0);
        checkOutput("async_write_reg", write_reg, 0);
        resetModel();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("post_reset_b_ready", b_ready, 1);
        checkOutput("post_reset_count", count, 0);

        // Starvation: B entry 5/55 waits behind a held ALU result until the forced stall.
        applyStimulus(1'b1, 5'd9, 64'd900, 1'b1, 5'd5, 64'd55, acc);
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            checkOutput("starve_no_stall", alu_stall, 0);
            applyStimulus(1'b1, 5'd9, 64'd900, 1'b0, 5'd0, 64'd0, acc);
            checkOutput("starve_a_write", write_reg, 9);
        end
        checkOutput("stall_asserted", alu_stall, 1);
        applyStimulus(1'b1, 5'd9, 64'd900, 1'b0, 5'd0, 64'd0, acc);
        checkOutput("stall_write_rd", write_reg, 5);
        checkOutput("stall_write_data", write_data, 55);
        checkOutput("stall_released", alu_stall, 0);
        applyStimulus(1'b1, 5'd9, 64'd900, 1'b0, 5'd0, 64'd0, acc);
        checkOutput("resume_a_rd", write_reg, 9);
        idleCycle();

        // Randomized traffic; B holds its offer until accepted.
        pend  = 1'b0;
        pRd   = '0;
        pData = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pend && $urandom_range(0, 99) < 45) begin
                pend  = 1'b1;
                pRd   = 5'($urandom_range(0, 31));
                pData = {32'($urandom), 32'($urandom)};
            end
            applyStimulus($urandom_range(0, 99) < 75, 5'($urandom_range(0, 31)),
                          {32'($urandom), 32'($urandom)}, pend, pRd, pData, acc);
            if (acc) pend = 1'b0;
        end
        guard = 0;
        while (mFifo.size() > 0 && guard < 20) begin
            idleCycle();
            guard++;
        end
        checkOutput("final_drain", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
